// File: rtl/change_dispenser.sv
// Coin-change dispenser: greedy quarter/dime/nickel payout from three coin tubes,
// with per-coin drop acknowledge, jam timeout and shortfall reporting.
module change_dispenser #(
    parameter int TIMEOUT    = 15,
    parameter int INIT_STOCK = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] change,
    input  logic       load_stock,
    input  logic [4:0] q_load,
    input  logic [4:0] d_load,
    input  logic [4:0] n_load,
    input  logic       coin_ack,
    output logic       eject_q,
    output logic       eject_d,
    output logic       eject_n,
    output logic [4:0] quarter_o,
    output logic [4:0] dime_o,
    output logic [4:0] nickel_o,
    output logic       busy,
    output logic       done,
    output logic [8:0] shortfall,
    output logic       jam
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SELECT = 3'd1;
    localparam logic [2:0] EJECT  = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam logic [1:0] COIN_Q = 2'd0;
    localparam logic [1:0] COIN_D = 2'd1;
    localparam logic [1:0] COIN_N = 2'd2;

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [4:0]    STOCK_RST  = 5'(INIT_STOCK);

    logic [2:0]    state_q,     state_d;
    logic [8:0]    remaining_q, remaining_d;
    logic [4:0]    q_stock_q,   q_stock_d;
    logic [4:0]    d_stock_q,   d_stock_d;
    logic [4:0]    n_stock_q,   n_stock_d;
    logic [1:0]    sel_q,       sel_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic [4:0]    quarter_q,   quarter_d;
    logic [4:0]    dime_q,      dime_d;
    logic [4:0]    nickel_q,    nickel_d;
    logic [8:0]    shortfall_q, shortfall_d;
    logic          jam_q,       jam_d;

    // NOTE: every _d starts as its _q so no path through the case leaves a latch.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        q_stock_d   = q_stock_q;
        d_stock_d   = d_stock_q;
        n_stock_d   = n_stock_q;
        sel_d       = sel_q;
        timer_d     = timer_q;
        quarter_d   = quarter_q;
        dime_d      = dime_q;
        nickel_d    = nickel_q;
        shortfall_d = shortfall_q;
        jam_d       = jam_q;

        case (state_q)
            IDLE: begin
                // A simultaneous load lands first, so the next SELECT sees the new stocks.
                if (load_stock) begin
                    q_stock_d = q_load;
                    d_stock_d = d_load;
                    n_stock_d = n_load;
                    jam_d     = 1'b0;
                end
                if (start) begin
                    remaining_d = change - (change % 9'd5);
                    quarter_d   = '0;
                    dime_d      = '0;
                    nickel_d    = '0;
                    shortfall_d = '0;
                    state_d     = SELECT;
                end
            end
            SELECT: begin
                if (remaining_q >= 9'd25 && q_stock_q != '0) begin
                    sel_d   = COIN_Q;
                    state_d = EJECT;
                end else if (remaining_q >= 9'd10 && d_stock_q != '0) begin
                    sel_d   = COIN_D;
                    state_d = EJECT;
                end else if (remaining_q >= 9'd5 && n_stock_q != '0) begin
                    sel_d   = COIN_N;
                    state_d = EJECT;
                end else begin
                    shortfall_d = remaining_q;
                    state_d     = DONE;
                end
            end
            EJECT: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // The ack is checked first so a drop on the final timer cycle still counts.
                if (coin_ack) begin
                    state_d = SELECT;
                    case (sel_q)
                        COIN_Q: begin
                            remaining_d = remaining_q - 9'd25;
                            if (q_stock_q != '0) q_stock_d = q_stock_q - 5'd1;
                            quarter_d = quarter_q + 5'd1;
                        end
                        COIN_D: begin
                            remaining_d = remaining_q - 9'd10;
                            if (d_stock_q != '0) d_stock_d = d_stock_q - 5'd1;
                            dime_d = dime_q + 5'd1;
                        end
                        default: begin
                            remaining_d = remaining_q - 9'd5;
                            if (n_stock_q != '0) n_stock_d = n_stock_q - 5'd1;
                            nickel_d = nickel_q + 5'd1;
                        end
                    endcase
                end else if (timer_q == TIMER_LAST) begin
                    jam_d   = 1'b1;
                    state_d = SELECT;
                    case (sel_q)
                        COIN_Q:  q_stock_d = '0;
                        COIN_D:  d_stock_d = '0;
                        default: n_stock_d = '0;
                    endcase
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            q_stock_q   <= STOCK_RST;
            d_stock_q   <= STOCK_RST;
            n_stock_q   <= STOCK_RST;
            sel_q       <= COIN_Q;
            timer_q     <= '0;
            quarter_q   <= '0;
            dime_q      <= '0;
            nickel_q    <= '0;
            shortfall_q <= '0;
            jam_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            q_stock_q   <= q_stock_d;
            d_stock_q   <= d_stock_d;
            n_stock_q   <= n_stock_d;
            sel_q       <= sel_d;
            timer_q     <= timer_d;
            quarter_q   <= quarter_d;
            dime_q      <= dime_d;
            nickel_q    <= nickel_d;
            shortfall_q <= shortfall_d;
            jam_q       <= jam_d;
        end
    end

    assign eject_q   = (state_q == EJECT) && (sel_q == COIN_Q);
    assign eject_d   = (state_q == EJECT) && (sel_q == COIN_D);
    assign eject_n   = (state_q == EJECT) && (sel_q == COIN_N);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign quarter_o = quarter_q;
    assign dime_o    = dime_q;
    assign nickel_o  = nickel_q;
    assign shortfall = shortfall_q;
    assign jam       = jam_q;

endmodule
